// File: rtl/param_regfile.sv
// param_regfile: multi-port register file with prioritised writes, busy scoreboard and sweep-clear FSM.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module param_regfile #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_req_i,
    output logic                   ready_o,
    input  logic [NUM_RD*AW-1:0]   rs_addr_i,
    output logic [NUM_RD*XLEN-1:0] rs_data_o,
    output logic [NUM_RD-1:0]      rs_busy_o,
    input  logic                   wr0_en_i,
    input  logic [AW-1:0]          wr0_addr_i,
    input  logic [XLEN-1:0]        wr0_data_i,
    input  logic                   wr1_en_i,
    input  logic [AW-1:0]          wr1_addr_i,
    input  logic [XLEN-1:0]        wr1_data_i,
    input  logic                   issue_en_i,
    input  logic [AW-1:0]          issue_addr_i
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e            state_q;
    logic [AW-1:0]     idx_q;
    logic              ready_q;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic              we0, we1, iss;

    // Register 0 is never written or allocated when hardwired to zero.
    assign we0 = ready_q & wr0_en_i & ~(ZERO_REG && (wr0_addr_i == '0));
    assign we1 = ready_q & wr1_en_i & ~(ZERO_REG && (wr1_addr_i == '0));
    assign iss = ready_q & issue_en_i & ~(ZERO_REG && (issue_addr_i == '0));
    assign ready_o = ready_q;

    // Scoreboard next state: writes retire, issue allocates (and wins), clear wipes everything.
    always_comb begin
        busy_d = busy_q;
        if (ready_q) begin
            if (we0) busy_d[wr0_addr_i] = 1'b0;
            if (we1) busy_d[wr1_addr_i] = 1'b0;
            if (iss) busy_d[issue_addr_i] = 1'b1;
            if (clr_req_i) busy_d = '0;
        end
    end

    // Sweep/run controller with registered ready and scoreboard.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (state_q == INIT) begin
                idx_q <= idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end else if (clr_req_i) begin
                state_q <= INIT;
                idx_q   <= '0;
                ready_q <= 1'b0;
            end
        end
    end

    // Storage has no reset: the sweep zeroes one entry per cycle; wr1 is assigned last so it wins.
    always_ff @(posedge clk_i) begin
        if (!ready_q) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (we0) mem_q[wr0_addr_i] <= wr0_data_i;
            if (we1) mem_q[wr1_addr_i] <= wr1_data_i;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        assign a = rs_addr_i[p*AW +: AW];
        // Combinational read; outputs are forced to zero while sweeping or for hardwired register 0.
        always_comb begin
            d = mem_q[a];
            b = busy_q[a];
`ifdef RF_BYPASS_EN
            if (we1 && (wr1_addr_i == a)) begin
                d = wr1_data_i;
                b = iss && (issue_addr_i == a);
            end else if (we0 && (wr0_addr_i == a)) begin
                d = wr0_data_i;
                b = iss && (issue_addr_i == a);
            end
`endif
            if (!ready_q || (ZERO_REG && (a == '0))) begin
                d = '0;
                b = 1'b0;
            end
        end
        assign rs_data_o[p*XLEN +: XLEN] = d;
        assign rs_busy_o[p] = b;
    end

endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: randomized bench for param_regfile against an array-based behavioural model.
module tb_param_regfile;

    localparam int XLEN = 32, DEPTH = 32, NUM_RD = 2, AW = 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   clr_req;
    logic                   ready;
    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_data;
    logic [NUM_RD-1:0]      rs_busy;
    logic                   wr0_en, wr1_en, issue_en;
    logic [AW-1:0]          wr0_addr, wr1_addr, issue_addr;
    logic [XLEN-1:0]        wr0_data, wr1_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_regfile #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_req_i(clr_req), .ready_o(ready),
        .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
        .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
        .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: contents, busy flags, and cycles elapsed since a sweep began.
    logic [XLEN-1:0] m_mem [DEPTH];
    bit              m_busy [DEPTH];
    bit              m_ready = 1'b0;
    int              m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b0;
            m_cnt = 0;
            for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
        end else if (!m_ready) begin
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
        end else begin
            if (wr0_en && wr0_addr != 0) begin m_mem[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
            if (wr1_en && wr1_addr != 0) begin m_mem[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            if (clr_req) begin
                m_ready = 1'b0;
                m_cnt = 0;
                for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
            end
        end
    end

    // Every-cycle compare of ready and all read ports against the model.
    logic [AW-1:0]   ca;
    logic [XLEN-1:0] ed;
    logic            eb;
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", 64'(ready), 64'(m_ready));
            for (int p = 0; p < NUM_RD; p++) begin
                ca = rs_addr[p*AW +: AW];
                ed = m_mem[ca];
                eb = m_busy[ca];
`ifdef RF_BYPASS_EN
                if (wr1_en && wr1_addr == ca) begin
                    ed = wr1_data; eb = issue_en && issue_addr == ca;
                end else if (wr0_en && wr0_addr == ca) begin
                    ed = wr0_data; eb = issue_en && issue_addr == ca;
                end
`endif
                if (!m_ready || ca == 0) begin ed = '0; eb = 1'b0; end
                check($sformatf("rs_data[%0d]", p), 64'(rs_data[p*XLEN +: XLEN]), 64'(ed));
                check($sformatf("rs_busy[%0d]", p), 64'(rs_busy[p]), 64'(eb));
            end
        end
    end

    task automatic idle();
        clr_req = 0; wr0_en = 0; wr1_en = 0; issue_en = 0;
        wr0_addr = '0; wr1_addr = '0; issue_addr = '0;
        wr0_data = '0; wr1_data = '0; rs_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(string name);
        int cnt = 0;
        while (!ready && cnt < 100) begin cyc(); cnt++; end
        check(name, 64'(cnt), 64'd32);
    endtask

    function automatic logic [AW-1:0] raddr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        wait_ready("init_len");
        // Single write then read back; write to register 0 is dropped.
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        cyc(); idle(); rs_addr[0 +: AW] = 5; #1;
        check("rd_addr5", 64'(rs_data[31:0]), 64'h00000000DEADBEEF);
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'h12345678;
        cyc(); idle(); rs_addr[0 +: AW] = 0; #1;
        check("rd_addr0", 64'(rs_data[31:0]), 64'h0);
        // Colliding writes: wr1 wins.
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1111;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2222;
        cyc(); idle(); rs_addr[0 +: AW] = 7; #1;
        check("wr_prio", 64'(rs_data[31:0]), 64'h2222);
        // Scoreboard set, cleared by write, issue beats write.
        issue_en = 1; issue_addr = 9;
        cyc(); idle(); rs_addr[0 +: AW] = 9; #1;
        check("busy_set", 64'(rs_busy[0]), 64'd1);
        wr1_en = 1; wr1_addr = 9; wr1_data = 32'hA5A5;
        cyc(); idle(); rs_addr[0 +: AW] = 9; #1;
        check("busy_clr", 64'(rs_busy[0]), 64'd0);
        check("rd_addr9", 64'(rs_data[31:0]), 64'hA5A5);
        issue_en = 1; issue_addr = 3; wr0_en = 1; wr0_addr = 3; wr0_data = 32'h3;
        cyc(); idle(); rs_addr[AW +: AW] = 3; #1;
        check("issue_wins", 64'(rs_busy[1]), 64'd1);
        // Same-cycle write/read of register 4.
        rs_addr[AW +: AW] = 4; wr0_en = 1; wr0_addr = 4; wr0_data = 32'hCAFE; #1;
`ifdef RF_BYPASS_EN
        check("bypass_now", 64'(rs_data[63:32]), 64'hCAFE);
`else
        check("bypass_now", 64'(rs_data[63:32]), 64'h0);
`endif
        cyc(); idle(); rs_addr[AW +: AW] = 4; #1;
        check("bypass_next", 64'(rs_data[63:32]), 64'hCAFE);
        // Sweep-clear with writes hammering during the sweep.
        wr0_en = 1; wr0_addr = 10; wr0_data = 32'h55; issue_en = 1; issue_addr = 9;
        cyc(); idle(); clr_req = 1;
        cyc(); idle(); #1;
        check("clr_ready0", 64'(ready), 64'd0);
        wr0_en = 1; wr0_addr = 10; wr0_data = 32'hFF; issue_en = 1; issue_addr = 10;
        wait_ready("clr_len");
        idle(); rs_addr[0 +: AW] = 10; rs_addr[AW +: AW] = 9; #1;
        check("clr_data10", 64'(rs_data[31:0]), 64'h0);
        check("clr_busy9", 64'(rs_busy[1]), 64'd0);
        // Reset in the middle of a sweep restarts it.
        clr_req = 1;
        cyc(); idle();
        repeat (10) cyc();
        rst_n = 0; #1;
        check("rst_ready0", 64'(ready), 64'd0);
        cyc(); cyc();
        rst_n = 1;
        wait_ready("rst_len");
        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 699) == 0) rst_n = 0;
            clr_req = ($urandom_range(0, 149) == 0);
            wr0_en = $urandom_range(0, 1) == 1; wr0_addr = raddr(); wr0_data = $urandom;
            wr1_en = $urandom_range(0, 2) == 0; wr1_addr = raddr(); wr1_data = $urandom;
            issue_en = $urandom_range(0, 2) == 0; issue_addr = raddr();
            for (int p = 0; p < NUM_RD; p++) rs_addr[p*AW +: AW] = raddr();
        end
        cyc(); idle(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
